// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stall/flush sequencing and forwarding selects for the 5-stage LEGv8 pipeline.
// Optional stall/flush performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int         CNT_W    = 16,
   parameter logic [4:0] ZERO_REG = 5'd31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      i_dec_inst,
   input  logic             i_dec_valid,
   input  logic             i_br_taken,
   output logic             o_stall,
   output logic             o_flush_if,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic [1:0]       o_fwd_dec,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef struct packed {
      logic       valid;
      logic       wr;
      logic       load;
      logic       setflags;
      logic [4:0] rd;
      logic [4:0] rn;
      logic [4:0] rm;
   } stage_t;

   typedef enum logic [1:0] {RUN, HOLD1, HOLD2} state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   stage_t     r_ex, r_mem, r_wb;
   stage_t     w_dec;
   state_t     r_state, w_nextState;
   logic [4:0] w_srcT, w_cmpReg;
   logic       w_isAddi, w_isAdds, w_isSubs, w_isLdur, w_isStur;
   logic       w_isBr, w_isCbz, w_isBl, w_isBlt;
   logic       w_loadUse, w_cmpEx, w_cmpMemLoad, w_flagHaz;
   logic       w_hazard, w_hazLong;

   function automatic logic hit(input stage_t s, input logic [4:0] r);
      return s.valid && s.wr && (r != ZERO_REG) && (s.rd == r);
   endfunction

   assign w_isAddi = (i_dec_inst[31:22] == 10'b1001000100);
   assign w_isAdds = (i_dec_inst[31:21] == 11'b10101011000);
   assign w_isSubs = (i_dec_inst[31:21] == 11'b11101011000);
   assign w_isLdur = (i_dec_inst[31:21] == 11'b11111000010);
   assign w_isStur = (i_dec_inst[31:21] == 11'b11111000000);
   assign w_isBr   = (i_dec_inst[31:21] == 11'b11010110000);
   assign w_isCbz  = (i_dec_inst[31:24] == 8'b10110100);
   assign w_isBl   = (i_dec_inst[31:26] == 6'b100101);
   assign w_isBlt  = (i_dec_inst[31:24] == 8'b01010100) && (i_dec_inst[4:0] == 5'b01011);

   // Unused operand slots hold ZERO_REG so they can never match a producer.
   always_comb begin
      w_dec          = '0;
      w_dec.valid    = 1'b1;
      w_dec.wr       = w_isAddi | w_isAdds | w_isSubs | w_isLdur | w_isBl;
      w_dec.load     = w_isLdur;
      w_dec.setflags = w_isAdds | w_isSubs;
      w_dec.rd       = w_isBl ? 5'd30 : (w_dec.wr ? i_dec_inst[4:0] : ZERO_REG);
      w_dec.rn       = (w_isAddi | w_isAdds | w_isSubs | w_isLdur | w_isStur | w_isBr) ?
                       i_dec_inst[9:5] : ZERO_REG;
      w_dec.rm       = (w_isAdds | w_isSubs) ? i_dec_inst[20:16] :
                       (w_isStur ? i_dec_inst[4:0] : ZERO_REG);
      w_srcT         = (w_isStur | w_isCbz) ? i_dec_inst[4:0] : ZERO_REG;
      w_cmpReg       = w_isCbz ? i_dec_inst[4:0] : (w_isBr ? i_dec_inst[9:5] : ZERO_REG);
   end

   assign w_loadUse    = r_ex.load && (hit(r_ex, w_dec.rn) || hit(r_ex, w_dec.rm) || hit(r_ex, w_srcT));
   assign w_cmpEx      = hit(r_ex, w_cmpReg);
   assign w_cmpMemLoad = hit(r_mem, w_cmpReg) && r_mem.load;
   assign w_flagHaz    = w_isBlt && r_ex.valid && r_ex.setflags;
   assign w_hazard     = i_dec_valid && (w_loadUse || w_cmpEx || w_cmpMemLoad || w_flagHaz);
   assign w_hazLong    = i_dec_valid && w_cmpEx && r_ex.load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_nextState;
   end

   // The registered state counts forced hold cycles still owed after the current stalled cycle.
   always_comb begin
      w_nextState = r_state;
      o_stall     = 1'b0;
      unique case (r_state)
         RUN: begin
            o_stall = w_hazard;
            if (w_hazLong) w_nextState = HOLD1;
         end
         HOLD2: begin
            o_stall     = 1'b1;
            w_nextState = HOLD1;
         end
         HOLD1: begin
            o_stall     = 1'b1;
            w_nextState = RUN;
         end
         default: w_nextState = RUN;
      endcase
   end

   assign o_flush_if = i_br_taken & ~o_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         if (o_stall || !i_dec_valid) r_ex <= '0;
         else                         r_ex <= w_dec;
      end
   end

   // A load still in MEM has no data yet, so the decode compare may only take MEM from ALU producers.
   always_comb begin
      o_fwd_a   = FWD_RF;
      o_fwd_b   = FWD_RF;
      o_fwd_dec = FWD_RF;
      if (hit(r_mem, r_ex.rn))     o_fwd_a = FWD_MEM;
      else if (hit(r_wb, r_ex.rn)) o_fwd_a = FWD_WB;
      if (hit(r_mem, r_ex.rm))     o_fwd_b = FWD_MEM;
      else if (hit(r_wb, r_ex.rm)) o_fwd_b = FWD_WB;
      if (i_dec_valid) begin
         if (hit(r_mem, w_cmpReg) && !r_mem.load) o_fwd_dec = FWD_MEM;
         else if (hit(r_wb, w_cmpReg))            o_fwd_dec = FWD_WB;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (o_stall && (r_stallCnt != '1))    r_stallCnt <= r_stallCnt + CNT_W'(1);
         if (o_flush_if && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
   end

   assign o_stall_cnt = r_stallCnt;
   assign o_flush_cnt = r_flushCnt;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule
